// File: rtl/ppi_pkg.sv
// Shared types and constants for the 8255 port A mode-1 output-handshake receiver.
package ppi_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    ACK     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // 8255 mode-1 port C bit positions for port A.
  localparam int PC_INTRA = 3;
  localparam int PC_STBA  = 4;
  localparam int PC_IBFA  = 5;
  localparam int PC_ACKA  = 6;
  localparam int PC_OBFA  = 7;

  // Bits needed for a counter that must hold values 0..max_val inclusive.
  function automatic int cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/ppi_obf_receiver_if.sv
// Bus bundle between the 8255 port A handshake, the receiver and its local byte consumer.
interface ppi_obf_receiver_if
  import ppi_pkg::*;
#(
  parameter int FIFO_DEPTH = 8
);
  logic [7:0]                     pa_data;
  logic                           obf_n;
  logic                           ack_n;
  logic [7:0]                     rx_data;
  logic                           rx_valid;
  logic                           rx_ready;
  logic [cnt_w(FIFO_DEPTH)-1:0]   fifo_count;
  logic                           overrun;
  logic                           timeout;
  logic                           clr_err;

  modport slave (
    input  pa_data, obf_n, rx_ready, clr_err,
    output ack_n, rx_data, rx_valid, fifo_count, overrun, timeout
  );

  modport master (
    output pa_data, obf_n, rx_ready, clr_err,
    input  ack_n, rx_data, rx_valid, fifo_count, overrun, timeout
  );
endinterface

// File: rtl/ppi_sync_fifo.sv
// First-word-fall-through byte FIFO; a push into a full FIFO is accepted only alongside a pop.
module ppi_sync_fifo
  import ppi_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  logic [DATA_W-1:0]         din,
  input  logic                      pop,
  output logic [DATA_W-1:0]         dout,
  output logic                      full,
  output logic                      empty,
  output logic [cnt_w(DEPTH)-1:0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cnt_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty FIFO presents zero rather than stale storage.
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ppi_obf_receiver.sv
// Peripheral-side consumer of the 8255 port A mode-1 OBFA#/ACKA# handshake with a byte FIFO.
// Define PPI_RX_TIMEOUT_EN to build the overrun/timeout watchdogs; otherwise both waits are unbounded.
module ppi_obf_receiver
  import ppi_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int ACK_WIDTH   = 4,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                  CLK,
  input  logic                  RESET,
  ppi_obf_receiver_if.slave     bus
);
  localparam int CNT_W  = cnt_w(FIFO_DEPTH);
  localparam int ACK_CW = cnt_w(ACK_WIDTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 ||
      ACK_WIDTH < 1 || TIMEOUT_CYC < 1) begin : g_bad_params
    $error("ppi_obf_receiver: illegal parameter combination");
  end

  logic              sync_p0, sync_p1;
  logic              obf_s;
  state_t            state, state_next;
  logic [ACK_CW-1:0] ack_cnt;
  logic              ack_q;
  logic              push, pop, full, empty;
  logic [CNT_W-1:0]  count;
  logic              tmo_hit;

  // Stage p0/p1: two-flop synchroniser for the asynchronous OBFA# level.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= bus.obf_n;
      sync_p1 <= sync_p0;
    end
  end

  assign obf_s = sync_p1;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!obf_s && !full) state_next = CAPTURE;
      CAPTURE: state_next = ACK;
      ACK:     if (ack_cnt == ACK_CW'(1)) state_next = RELEASE;
      RELEASE: begin
        if (obf_s)        state_next = IDLE;
        else if (tmo_hit) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // ACKA# is registered from the next state so the 8255 pin never glitches.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state   <= IDLE;
      ack_cnt <= '0;
      ack_q   <= 1'b1;
    end else begin
      state <= state_next;
      ack_q <= (state_next != ACK);
      if (state == CAPTURE)  ack_cnt <= ACK_CW'(ACK_WIDTH);
      else if (state == ACK) ack_cnt <= ack_cnt - ACK_CW'(1);
    end
  end

  // PA has been stable since before OBFA# fell, so it is sampled raw here.
  assign push = (state == CAPTURE);
  assign pop  = bus.rx_ready && !empty;

  ppi_sync_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RESET),
    .push  (push),
    .din   (bus.pa_data),
    .pop   (pop),
    .dout  (bus.rx_data),
    .full  (full),
    .empty (empty),
    .count (count)
  );

`ifdef PPI_RX_TIMEOUT_EN
  localparam int TMO_CW = cnt_w(TIMEOUT_CYC);

  logic [TMO_CW-1:0] tmo_cnt;
  logic              stall, waiting;
  logic              overrun_q, timeout_q;

  // One counter serves both waits; it restarts on every state change and saturates.
  assign stall   = (state == IDLE) && !obf_s && full;
  assign waiting = (state == RELEASE) && !obf_s;
  assign tmo_hit = (stall || waiting) && (tmo_cnt == TMO_CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      tmo_cnt   <= '0;
      overrun_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (!(stall || waiting) || (state_next != state))
        tmo_cnt <= '0;
      else if (tmo_cnt != TMO_CW'(TIMEOUT_CYC))
        tmo_cnt <= tmo_cnt + TMO_CW'(1);

      if (stall && tmo_hit)     overrun_q <= 1'b1;
      else if (bus.clr_err)     overrun_q <= 1'b0;

      if (waiting && tmo_hit)   timeout_q <= 1'b1;
      else if (bus.clr_err)     timeout_q <= 1'b0;
    end
  end

  assign bus.overrun = overrun_q;
  assign bus.timeout = timeout_q;
`else
  logic unused_clr_err;

  assign tmo_hit        = 1'b0;
  assign unused_clr_err = bus.clr_err;
  assign bus.overrun    = 1'b0;
  assign bus.timeout    = 1'b0;
`endif

  assign bus.ack_n      = ack_q;
  assign bus.rx_valid   = !empty;
  assign bus.fifo_count = count;

endmodule

// File: tb/tb_ppi_obf_receiver.sv
// Directed bench for ppi_obf_receiver: handshake timing, FIFO fill/drain, watchdogs and reset.
module tb_ppi_obf_receiver;
  import ppi_pkg::*;

`ifdef PPI_RX_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  ppi_obf_receiver_if #(.FIFO_DEPTH(8)) bus ();

  ppi_obf_receiver #(
    .FIFO_DEPTH  (8),
    .ACK_WIDTH   (4),
    .TIMEOUT_CYC (1024)
  ) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  int         lat, width;
  logic       saw_ack;
  logic [7:0] q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Drive one byte through the full handshake; lat counts edges from the drive to ACKA# low.
  task automatic send_byte(input logic [7:0] b, output int l, output int w);
    bus.pa_data = b;
    bus.obf_n   = 1'b0;
    l = 0;
    while (bus.ack_n && l < 40) begin tick(1); l++; end
    w = 0;
    while (!bus.ack_n && w < 40) begin tick(1); w++; end
    tick(2);
    bus.obf_n = 1'b1;
    tick(3);
  endtask

  initial begin
    RESET        = 1'b1;
    bus.obf_n    = 1'b1;
    bus.pa_data  = 8'h00;
    bus.rx_ready = 1'b0;
    bus.clr_err  = 1'b0;
    tick(3);
    check("rst ack_n",      bus.ack_n,      1);
    check("rst rx_valid",   bus.rx_valid,   0);
    check("rst fifo_count", bus.fifo_count, 0);
    check("rst overrun",    bus.overrun,    0);
    check("rst timeout",    bus.timeout,    0);
    check("rst rx_data",    bus.rx_data,    0);
    check("rst state",      int'(dut.state), int'(IDLE));
    RESET = 1'b0;
    tick(2);

    // Single byte; latency measured from the first edge that samples obf_n low.
    send_byte(8'hA5, lat, width);
    check("single latency",   lat - 1,        3);
    check("single ack width", width,          4);
    check("single rx_data",   bus.rx_data,    8'hA5);
    check("single rx_valid",  bus.rx_valid,   1);
    check("single count",     bus.fifo_count, 1);
    check("single state",     int'(dut.state), int'(IDLE));
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("single pop count", bus.fifo_count, 0);
    check("single pop valid", bus.rx_valid,   0);

    // Burst of eight fills the FIFO; the ninth must stall without an ack.
    for (int i = 0; i < 8; i++) send_byte(8'(i), lat, width);
    check("burst full count", bus.fifo_count, 8);
    bus.pa_data = 8'h08;
    bus.obf_n   = 1'b0;
    tick(30);
    check("stall no ack",  bus.ack_n, 1);
    check("stall state",   int'(dut.state), int'(IDLE));
    tick(995);
    check("overrun before limit", bus.overrun, 0);
    tick(1);
    check("overrun at limit", bus.overrun, TMO_EN);
    check("stall count",      bus.fifo_count, 8);

    bus.rx_ready = 1'b1;
    saw_ack = 1'b0;
    q.delete();
    for (int i = 0; i < 20; i++) begin
      if (bus.rx_valid) q.push_back(bus.rx_data);
      tick(1);
      if (!bus.ack_n) saw_ack = 1'b1;
    end
    bus.rx_ready = 1'b0;
    bus.obf_n    = 1'b1;
    tick(3);
    check("ninth acked",  saw_ack, 1);
    check("drain size",   q.size(), 9);
    for (int i = 0; i < q.size() && i < 9; i++) check($sformatf("drain[%0d]", i), q[i], i);
    check("drain count",  bus.fifo_count, 0);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("overrun cleared", bus.overrun, 0);

    // Pop in the CAPTURE cycle with three queued: count holds, order kept.
    send_byte(8'h10, lat, width);
    send_byte(8'h11, lat, width);
    send_byte(8'h12, lat, width);
    check("pp pre count", bus.fifo_count, 3);
    bus.pa_data = 8'h13;
    bus.obf_n   = 1'b0;
    tick(3);
    check("pp capture state", int'(dut.state), int'(CAPTURE));
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    check("pp count",  bus.fifo_count, 3);
    check("pp head",   bus.rx_data,    8'h11);
    width = 0;
    while (!bus.ack_n && width < 40) begin tick(1); width++; end
    bus.obf_n = 1'b1;
    tick(3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pp order[%0d]", i), bus.rx_data, 8'h11 + i);
      bus.rx_ready = 1'b1;
      tick(1);
      bus.rx_ready = 1'b0;
    end
    check("pp drained", bus.fifo_count, 0);

    // Reset asserted in the second ACK cycle.
    bus.pa_data = 8'h77;
    bus.obf_n   = 1'b0;
    tick(4);
    check("mid-ack low", bus.ack_n, 0);
    tick(1);
    RESET = 1'b1;
    tick(1);
    check("mid-ack rst ack_n", bus.ack_n,      1);
    check("mid-ack rst count", bus.fifo_count, 0);
    check("mid-ack rst valid", bus.rx_valid,   0);
    check("mid-ack rst state", int'(dut.state), int'(IDLE));
    RESET     = 1'b0;
    bus.obf_n = 1'b1;
    tick(3);

    // Stuck OBFA#: one ack, then the watchdog (if built) forces a recapture.
    bus.pa_data = 8'h5A;
    bus.obf_n   = 1'b0;
    lat = 0;
    while (bus.ack_n && lat < 40) begin tick(1); lat++; end
    width = 0;
    while (!bus.ack_n && width < 40) begin tick(1); width++; end
    check("stuck first ack width", width, 4);
    tick(1023);
    check("stuck timeout before", bus.timeout, 0);
    check("stuck single capture", bus.fifo_count, 1);
    tick(1);
    check("stuck timeout at limit", bus.timeout, TMO_EN);
    check("stuck state", int'(dut.state), TMO_EN ? int'(IDLE) : int'(RELEASE));
    tick(4);
    check("stuck recapture count", bus.fifo_count, TMO_EN ? 2 : 1);
    check("stuck second ack", bus.ack_n, !TMO_EN);
    check("stuck head", bus.rx_data, 8'h5A);
    bus.clr_err = 1'b1;
    tick(1);
    bus.clr_err = 1'b0;
    check("timeout cleared", bus.timeout, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
